// File: rtl/redtin_uart_pkg.sv
// Shared definitions for the Red Tin host-channel UART receiver.
package redtin_uart_pkg;

    // Bit period for 115200 baud from the 20 MHz board clock.
    localparam int unsigned CLK_DIV_115200 = 174;

    // Frame geometry (8 data bits, one start, one stop, optional parity).
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned START_BITS = 1;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

    // Receiver state encoding.
    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } state_e;

    // Even parity bit of a data byte.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/redtin_sync2.sv
// Two-flop synchronizer with configurable reset value; shared with button inputs.
module redtin_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/redtin_uart_rx.sv
// UART receiver for the Red Tin host command channel (8N1, mid-bit sampling).
// Optional even-parity bit enabled by defining REDTIN_UART_RX_PARITY_EN.
module redtin_uart_rx
    import redtin_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_115200,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_en,
    output logic       rx_framing_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

    logic rxs;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             en_q,    en_d;
    logic             ferr_q,  ferr_d;
    logic             perr_q,  perr_d;
    logic             busy_q,  busy_d;
`ifdef REDTIN_UART_RX_PARITY_EN
    logic             par_q,   par_d;
`endif

    logic cnt_zero;
    assign cnt_zero = (cnt_q == '0);

    redtin_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .d_i    (uart_rx),
        .q_o    (rxs)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef REDTIN_UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
`ifdef REDTIN_UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: bit timing, sampling and frame checks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        en_d    = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        busy_d  = busy_q;
`ifdef REDTIN_UART_RX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_WAIT_IDLE: begin
                if (!rxs) begin
                    cnt_d = '0;
                end else if (cnt_q == BIT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LAST;
                    busy_d  = 1'b1;
                end
            end

            ST_START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    // Line went back high by mid-bit: treat as a glitch.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    cnt_d   = BIT_LAST;
                end
            end

            ST_DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = BIT_LAST;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef REDTIN_UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef REDTIN_UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    par_d   = rxs;
                    cnt_d   = BIT_LAST;
                    state_d = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    busy_d = 1'b0;
                    if (!rxs) begin
                        // Low stop bit: break or lost sync, wait for a clean idle line.
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
`ifdef REDTIN_UART_RX_PARITY_EN
                        if (par_q != even_parity(shift_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            en_d   = 1'b1;
                        end
`else
                        data_d = shift_q;
                        en_d   = 1'b1;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rx_data        = data_q;
    assign rx_en          = en_q;
    assign rx_framing_err = ferr_q;
    assign rx_parity_err  = perr_q;
    assign rx_busy        = busy_q;

endmodule

// File: tb/tb_redtin_uart_rx.sv
// Self-checking bench for redtin_uart_rx; honours REDTIN_UART_RX_PARITY_EN.
module tb_redtin_uart_rx;

    localparam int D  = 16;
    localparam int H  = D / 2;
    localparam int D2 = 174;
`ifdef REDTIN_UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic       uart_rx2;
    logic [7:0] rx_data,  rx_data2;
    logic       rx_en,    rx_en2;
    logic       rx_framing_err, rx_framing_err2;
    logic       rx_parity_err,  rx_parity_err2;
    logic       rx_busy,  rx_busy2;

    redtin_uart_rx #(.CLK_DIV(D), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .rx_data(rx_data), .rx_en(rx_en), .rx_framing_err(rx_framing_err),
        .rx_parity_err(rx_parity_err), .rx_busy(rx_busy)
    );

    redtin_uart_rx u_dut174 (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx2),
        .rx_data(rx_data2), .rx_en(rx_en2), .rx_framing_err(rx_framing_err2),
        .rx_parity_err(rx_parity_err2), .rx_busy(rx_busy2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected strobe: kind 0 = byte, 1 = framing error, 2 = parity error.
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         strobe_t[$];
    logic [7:0] model_data = 8'h00;
    bit         chk_en = 1'b0;
    bit         bad2 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    exp_t ce;
    int   cn;
    int   ck;

    // Per-cycle comparison of the DUT against the expected-strobe queue.
    always @(negedge clk) begin
        if (chk_en) begin
            cn = int'(rx_en) + int'(rx_framing_err) + int'(rx_parity_err);
            chk("strobes_exclusive", 32'(cn <= 1), 32'd1);
            if (cn > 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {29'd0, rx_en, rx_framing_err, rx_parity_err}, 32'd0);
                end else begin
                    ce = exp_q.pop_front();
                    ck = rx_en ? 0 : (rx_framing_err ? 1 : 2);
                    chk("strobe_kind", ck, ce.kind);
                    checks++;
                    if (cyc < ce.due - 1 || cyc > ce.due + 1) begin
                        errors++;
                        $display("FAIL strobe_time: got cycle %0d, want %0d", cyc, ce.due);
                    end
                    chk("busy_at_strobe", rx_busy, 0);
                    if (ce.kind == 0) model_data = ce.data;
                    if (rx_en) strobe_t.push_back(cyc);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].due + 1) begin
                checks++;
                errors++;
                $display("FAIL missed_strobe: got none by cycle %0d, want kind %0d at %0d",
                         cyc, exp_q[0].kind, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            chk("rx_data", rx_data, model_data);
        end
    end

    always @(negedge clk) if (rx_framing_err2 || rx_parity_err2) bad2 = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int line, input logic v);
        if (line == 0) uart_rx = v;
        else           uart_rx2 = v;
    endtask

    // Drive one frame on the selected line, one bit every div cycles.
    task automatic drive_frame(input int line, input int div, input logic [7:0] d,
                               input bit stop_v, input bit par_flip, input bit busy_chk);
        logic [10:0] bits;
        int          nbits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef REDTIN_UART_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_v;
        nbits    = 11;
`else
        bits[9]  = stop_v;
        nbits    = 10;
        if (par_flip) bits[10] = 1'b1;
`endif
        for (int i = 0; i < nbits; i++) begin
            set_line(line, bits[i]);
            if (busy_chk && i == 4) begin
                repeat (div / 2) tick();
                chk("busy_mid_frame", rx_busy, 1);
                repeat (div - div / 2) tick();
            end else begin
                repeat (div) tick();
            end
        end
    endtask

    // Send a frame on the main line and record what the receiver must report.
    task automatic send(input logic [7:0] d, input bit stop_v, input bit par_flip);
        exp_t e;
        e.data = d;
        e.due  = (cyc + 1) + 2 + H + NB * D;
        if (!stop_v)       e.kind = 1;
`ifdef REDTIN_UART_RX_PARITY_EN
        else if (par_flip) e.kind = 2;
`endif
        else               e.kind = 0;
        exp_q.push_back(e);
        drive_frame(0, D, d, stop_v, par_flip, 1'b1);
    endtask

    initial begin
        int         sz;
        int         r;
        bit         found;
        logic [7:0] rd;
        logic [7:0] v77;

        rst_n    = 1'b0;
        uart_rx  = 1'b1;
        uart_rx2 = 1'b1;
        repeat (3) tick();
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_en", rx_en, 0);
        chk("rst_framing", rx_framing_err, 0);
        chk("rst_parity", rx_parity_err, 0);
        chk("rst_busy", rx_busy, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (20) tick();

        // Single frame.
        send(8'hA5, 1'b1, 1'b0);
        repeat (20) tick();
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_busy_after", rx_busy, 0);
        chk("a5_one_strobe", strobe_t.size(), 1);

        // Back-to-back frames with no idle gap.
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b0);
        repeat (20) tick();
        sz = strobe_t.size();
        chk("b2b_count", sz, 4);
        if (sz >= 3) begin
            chk("b2b_spacing1", strobe_t[sz-2] - strobe_t[sz-3], 160);
            chk("b2b_spacing2", strobe_t[sz-1] - strobe_t[sz-2], 160);
        end
        chk("b2b_last", rx_data, 8'h55);

        // Short low glitch on an idle line is a false start.
        uart_rx = 1'b0;
        repeat (4) tick();
        uart_rx = 1'b1;
        repeat (H + 4) tick();
        chk("glitch_busy", rx_busy, 0);
        send(8'h3C, 1'b1, 1'b0);
        repeat (5) tick();

        // Framing error, long break, then resync only after a full idle bit.
        send(8'h81, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (40) tick();
        chk("ferr_data_kept", rx_data, 8'h3C);
        uart_rx = 1'b1;
        repeat (10) tick();
        drive_frame(0, D, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        send(8'h42, 1'b1, 1'b0);
        repeat (5) tick();
        chk("resync_data", rx_data, 8'h42);

        // Reset in the middle of the data bits of a 0x77 frame.
        v77     = 8'h77;
        uart_rx = 1'b0;
        repeat (D) tick();
        for (int j = 0; j < 3; j++) begin
            uart_rx = v77[j];
            repeat (D) tick();
        end
        uart_rx = v77[3];
        repeat (H) tick();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_en", rx_en, 0);
        chk("midrst_framing", rx_framing_err, 0);
        chk("midrst_parity", rx_parity_err, 0);
        chk("midrst_busy", rx_busy, 0);
        rst_n      = 1'b1;
        uart_rx    = 1'b1;
        exp_q.delete();
        model_data = 8'h00;
        chk_en     = 1'b1;
        repeat (20) tick();
        send(8'h19, 1'b1, 1'b0);
        repeat (5) tick();
        chk("post_rst_data", rx_data, 8'h19);

`ifdef REDTIN_UART_RX_PARITY_EN
        send(8'h03, 1'b1, 1'b0);
        send(8'h03, 1'b1, 1'b1);
        repeat (5) tick();
        chk("par_data_kept", rx_data, 8'h03);
`endif

        // Randomized traffic: good frames, glitches, framing and parity errors.
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 9));
            rd = 8'($urandom);
            if (r == 0) begin
                uart_rx = 1'b0;
                repeat ($urandom_range(1, H - 2)) tick();
                uart_rx = 1'b1;
                repeat (H + 4) tick();
            end else if (r == 1) begin
                send(rd, 1'b0, 1'b0);
                uart_rx = 1'b1;
                repeat (16 + $urandom_range(0, 8)) tick();
            end else begin
`ifdef REDTIN_UART_RX_PARITY_EN
                send(rd, 1'b1, r == 2);
`else
                send(rd, 1'b1, 1'b0);
`endif
                repeat ($urandom_range(0, 20)) tick();
            end
        end

        // Default divider instance at exact 115200 timing.
        repeat (200) tick();
        found = 1'b0;
        fork
            drive_frame(1, D2, 8'hC3, 1'b1, 1'b0, 1'b0);
            begin
                int i;
                i = 0;
                while (!found && i < 12 * D2) begin
                    @(negedge clk);
                    if (rx_en2) found = 1'b1;
                    i++;
                end
            end
        join
        chk("div174_seen", found, 1);
        chk("div174_data", rx_data2, 8'hC3);
        chk("div174_no_err", bad2, 0);

        repeat (50) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
